// File: rtl/z480_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z480_wb_arbiter (with z480_pkg)                              |
// | Description : Writeback/CDB arbiter: one holding slot per functional unit, |
// |               rotating-priority pick, registered result broadcast bus.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package z480_pkg;

  typedef enum logic [2:0] {
    FU_INT    = 3'd0,
    FU_BRANCH = 3'd1,
    FU_MULDIV = 3'd2,
    FU_VEC    = 3'd3,
    FU_MEM    = 3'd4
  } z480_fu_e;

  // 110-bit writeback record; carried through the arbiter untouched.
  typedef struct packed {
    logic [6:0]  rob_idx;
    logic        prd_valid;
    logic [6:0]  prd;
    logic [63:0] value;
    logic [30:0] flags;
  } z480_wb_t;

endpackage

module z480_wb_arbiter
  import z480_pkg::*;
#(
  parameter int N_REQ = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  z480_wb_t [N_REQ-1:0] req_wb,
  input  logic                 flush,
  output logic                 wb_valid,
  output z480_wb_t             wb,
  output logic [2:0]           wb_fu,
  output logic                 busy
);

  localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_IW = c_PW + 1;

  logic [N_REQ-1:0] r_slot_v;
  z480_wb_t         r_slot [N_REQ];
  logic [c_PW-1:0]  r_ptr;
  logic             r_wb_valid;
  z480_wb_t         r_wb;
  logic [2:0]       r_wb_fu;

  logic [N_REQ-1:0] w_gnt;
  logic [N_REQ-1:0] w_accept;
  logic [c_PW-1:0]  w_win;
  logic [c_PW-1:0]  w_pos;
  logic [c_IW-1:0]  w_idx;
  logic             w_any;

  // Rotating search from r_ptr; only held slots compete, never raw requests.
  always_comb begin
    w_gnt = '0;
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    w_pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + c_IW'(k);
      if (w_idx >= c_IW'(N_REQ)) begin
        w_idx = w_idx - c_IW'(N_REQ);
      end
      w_pos = w_idx[c_PW-1:0];
      if (!w_any && r_slot_v[w_pos]) begin
        w_any = 1'b1;
        w_win = w_pos;
        w_gnt = N_REQ'(1) << w_pos;
      end
    end
  end

  // A slot being drained this cycle can take a new result at the same edge.
  assign req_ready = {N_REQ{rst_n & ~flush}} & (~r_slot_v | w_gnt);
  assign w_accept  = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot_v   <= '0;
      r_ptr      <= '0;
      r_wb_valid <= 1'b0;
      r_wb       <= '0;
      r_wb_fu    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_slot[i] <= '0;
      end
    end else if (flush) begin
      r_slot_v   <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_accept[i]) begin
          r_slot_v[i] <= 1'b1;
          r_slot[i]   <= req_wb[i];
        end else if (w_gnt[i]) begin
          r_slot_v[i] <= 1'b0;
        end
      end
      if (w_any) begin
        r_wb       <= r_slot[w_win];
        r_wb_fu    <= 3'(w_win);
        r_wb_valid <= 1'b1;
        r_ptr      <= (w_win == c_PW'(N_REQ - 1)) ? '0 : w_win + c_PW'(1);
      end else begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb       = r_wb;
  assign wb_fu    = r_wb_fu;
  assign busy     = (|r_slot_v) | r_wb_valid;

endmodule

`default_nettype wire
